// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch program counter with return-address stack
// Priority per edge: rst, stall, soft reset, return, call, jump, increment.
module program_counter #(
  parameter int CNTR_WIDTH  = 8,
  parameter int STACK_DEPTH = 8,
  parameter int SP_WIDTH    = $clog2(STACK_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  jmp,
  input  logic                  cal_f,
  input  logic                  ret_f,
  input  logic                  rst_f,
  input  logic [CNTR_WIDTH-1:0] jmp_addr,
  output logic [CNTR_WIDTH-1:0] pc,
  output logic [SP_WIDTH-1:0]   sp,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  ovf_err,
  output logic                  unf_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [SP_WIDTH-1:0] DEPTH_SP = SP_WIDTH'(STACK_DEPTH);

  logic [CNTR_WIDTH-1:0] pc_q, pc_d;
  logic [SP_WIDTH-1:0]   sp_q, sp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [CNTR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [CNTR_WIDTH-1:0] pc_inc;
  logic [SP_WIDTH-1:0]   sp_dec;
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      pop_idx;
  logic                  push_en;
  logic                  is_empty;
  logic                  is_full;

  assign pc_inc   = pc_q + CNTR_WIDTH'(1);
  assign sp_dec   = sp_q - SP_WIDTH'(1);
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = sp_dec[IDX_W-1:0];
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == DEPTH_SP);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (en) begin
      if (!rst_f) begin
        pc_d = '0;
        sp_d = '0;
      end else if (ret_f) begin
        // Return wins over call when both are set; jmp_addr is never used here.
        if (!is_empty) begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_dec;
        end else begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (cal_f) begin
        if (!is_full) begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_WIDTH'(1);
          pc_d    = jmp_addr;
        end else begin
          ovf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (jmp) begin
        pc_d = jmp_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents need no reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign stack_empty = is_empty;
  assign stack_full  = is_full;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule
